// File: rtl/systolic_mm_sequencer.sv
// Job-level sequencer for the systolic matrix multiplier: walks CLEAR, FEED and DRAIN,
// then holds the result valid until the consumer acknowledges it.
module systolic_mm_sequencer #(
  parameter int L2 = 9,
  parameter int X  = 4,
  parameter int Y  = 25,
  parameter int CW = 16,
  localparam int D  = X + Y - 1,
  localparam int PW = $clog2(((L2 > D) ? L2 : D) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          res_ack,
  output logic          ready,
  output logic          on,
  output logic          sn,
  output logic          busy,
  output logic          res_valid,
  output logic [PW-1:0] phase_cnt,
  output logic [CW-1:0] jobs_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] jobs_q, jobs_d;
  logic          ready_q, on_q, sn_q, busy_q, valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jobs_d  = jobs_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == PW'(L2 - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == PW'(D - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (res_ack) begin
          state_d = S_IDLE;
          jobs_d  = jobs_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides any completion in the same cycle, so the job is never counted.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      jobs_d  = jobs_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      jobs_q  <= '0;
      ready_q <= 1'b1;
      on_q    <= 1'b0;
      sn_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jobs_q  <= jobs_d;
      ready_q <= (state_d == S_IDLE);
      on_q    <= (state_d == S_FEED);
      sn_q    <= (state_d == S_FEED) || (state_d == S_DRAIN) || (state_d == S_DONE);
      busy_q  <= (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
      valid_q <= (state_d == S_DONE);
    end
  end

  assign ready     = ready_q;
  assign on        = on_q;
  assign sn        = sn_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign phase_cnt = cnt_q;
  assign jobs_done = jobs_q;

endmodule
